// File: rtl/cpu_control.sv
// cpu_control: instruction sequencer and 8x16 register file driving a multi-cycle arithmetic unit
module cpu_control #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [2:0]  alu_op_code,
  output logic [15:0] alu_src1,
  output logic [15:0] alu_src2,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [15:0] disp_value,
  output logic        disp_valid,
  output logic        error
);
  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DECODE, WAIT} state_t;
  state_t        state_q, state_d;
  logic [15:0]   instr_q, instr_d;
  logic [15:0]   regs_q [8];
  logic [15:0]   regs_d [8];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    alu_op_code_q, alu_op_code_d;
  logic [15:0]   alu_src1_q, alu_src1_d;
  logic [15:0]   alu_src2_q, alu_src2_d;
  logic          wb_valid_q, wb_valid_d;
  logic [2:0]    wb_addr_q, wb_addr_d;
  logic [15:0]   wb_data_q, wb_data_d;
  logic [15:0]   disp_value_q, disp_value_d;
  logic          disp_valid_q, disp_valid_d;
  logic          error_q, error_d;
  logic [2:0]    op, rd, rs1, rs2;
  logic [6:0]    imm7;
  assign op          = instr_q[15:13];
  assign rd          = instr_q[12:10];
  assign rs1         = instr_q[9:7];
  assign rs2         = instr_q[6:4];
  assign imm7        = instr_q[6:0];
  assign instr_ready = state_q == IDLE;
  assign alu_op_code = alu_op_code_q;
  assign alu_src1    = alu_src1_q;
  assign alu_src2    = alu_src2_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign disp_value  = disp_value_q;
  assign disp_valid  = disp_valid_q;
  assign error       = error_q;
  // next-state: accept, decode/execute, and wait for the arithmetic unit with timeout
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    regs_d        = regs_q;
    cnt_d         = cnt_q;
    alu_op_code_d = alu_op_code_q;
    alu_src1_d    = alu_src1_q;
    alu_src2_d    = alu_src2_q;
    wb_valid_d    = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    disp_value_d  = disp_value_q;
    disp_valid_d  = 1'b0;
    error_d       = error_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        instr_d = instr;
        state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        case (op)
          3'b000: begin
            regs_d[rd] = {6'b0, instr_q[9:0]};
            wb_valid_d = 1'b1;
            wb_addr_d  = rd;
            wb_data_d  = {6'b0, instr_q[9:0]};
          end
          3'b110: for (int i = 0; i < 8; i++) regs_d[i] = '0;
          3'b111: begin
            disp_value_d = regs_q[rd];
            disp_valid_d = 1'b1;
          end
          default: begin
            alu_op_code_d = op;
            alu_src1_d    = regs_q[rs1];
            alu_src2_d    = (op == 3'b010 || op == 3'b100) ? {9'b0, imm7} : regs_q[rs2];
            cnt_d         = '0;
            state_d       = WAIT;
          end
        endcase
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (alu_done) begin
          regs_d[rd]    = alu_result;
          wb_valid_d    = 1'b1;
          wb_addr_d     = rd;
          wb_data_d     = alu_result;
          alu_op_code_d = 3'b000;
          state_d       = IDLE;
        end else if (cnt_q == CW'(ALU_TIMEOUT - 1)) begin
          error_d       = 1'b1;
          alu_op_code_d = 3'b000;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      regs_q        <= '{default: '0};
      cnt_q         <= '0;
      alu_op_code_q <= '0;
      alu_src1_q    <= '0;
      alu_src2_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      disp_value_q  <= '0;
      disp_valid_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      regs_q        <= regs_d;
      cnt_q         <= cnt_d;
      alu_op_code_q <= alu_op_code_d;
      alu_src1_q    <= alu_src1_d;
      alu_src2_q    <= alu_src2_d;
      wb_valid_q    <= wb_valid_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      disp_value_q  <= disp_value_d;
      disp_valid_q  <= disp_valid_d;
      error_q       <= error_d;
    end
  end
endmodule

// File: doc/cpu_control.md
# cpu_control

Instruction sequencer and register file for the CPU datapath. It accepts one 16-bit instruction at a time over a valid/ready handshake, reads operands from an internal 8×16 register file, and drives the 3-cycle arithmetic unit (ADD, ADDI, SUB, SUBI, MUL, signalled by a `done` pulse). It writes results back and executes the non-arithmetic instructions (LDI, CLR, DISP) itself. It sits between the instruction source (switch/memory front end) and the arithmetic unit.

## Interface
Parameters:
- `ALU_TIMEOUT`, default 15: WAIT cycles without `alu_done` before the operation is aborted.

Ports:
- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `instr`, input, 16: instruction word, sampled on accept.
- `instr_valid`, input, 1: `instr` is valid.
- `instr_ready`, output, 1: controller can accept; high only in IDLE.
- `alu_op_code`, output, 3: opcode to the arithmetic unit; 3'b000 = no operation.
- `alu_src1`, output, 16: operand 1.
- `alu_src2`, output, 16: operand 2 or zero-extended immediate.
- `alu_result`, input, 16: result from the arithmetic unit.
- `alu_done`, input, 1: arithmetic unit finished.
- `wb_valid`, output, 1: one-cycle pulse, register written this cycle.
- `wb_addr`, output, 3: destination register of the write.
- `wb_data`, output, 16: value written.
- `disp_value`, output, 16: last DISP value; held until the next DISP.
- `disp_valid`, output, 1: one-cycle pulse with each DISP.
- `error`, output, 1: sticky timeout flag; cleared only by reset.

## Operation
Instruction format: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [6:0] imm7 (bit 6 = sign, [5:0] = magnitude; the arithmetic unit interprets the sign).

Opcodes:
- 000 LDI: rd <= {6'b0, instr[9:0]}.
- 001 ADD, 011 SUB, 101 MUL: src1 = R[rs1], src2 = R[rs2].
- 010 ADDI, 100 SUBI: src1 = R[rs1], src2 = {9'b0, imm7}.
- 110 CLR: all 8 registers <= 0. No `wb_valid` pulse.
- 111 DISP: disp_value <= R[rd], `disp_valid` pulse.

States:
- IDLE: `instr_ready` = 1. When `instr_valid` is high, latch `instr` and go to DECODE.
- DECODE: LDI, CLR and DISP complete at this edge and go to IDLE. Arithmetic ops register `alu_op_code`, `alu_src1` and `alu_src2`, clear the timeout counter, and go to WAIT.
- WAIT: hold `alu_op_code`, `alu_src1` and `alu_src2` stable. The timeout counter increments each cycle.
  - When `alu_done` = 1 is sampled: R[rd] <= `alu_result`, pulse `wb_valid`, drive `alu_op_code` <= 000 at the same edge, and go to IDLE. Forcing 000 prevents the arithmetic unit from restarting when it returns to its start state.
  - When the counter reaches `ALU_TIMEOUT` with no `alu_done`: `error` <= 1, `alu_op_code` <= 000, no write, go to IDLE.
- `alu_op_code` is 000 in every state except WAIT.
- `alu_done` sampled outside WAIT is ignored.
- All 8 registers are writable, including R0.
- Arithmetic is done entirely in the arithmetic unit. The result is taken as 16 bits; MUL overflow is truncated by the unit.
- Source and destination may be the same register (e.g. ADD R1,R1,R1). Operands are captured in DECODE, so the result is well defined.

## Timing
- Reset (`rst_n` = 0 at an edge, including mid-WAIT):
  - state = IDLE; registers R0..R7 = 0.
  - `alu_op_code` = 000, `alu_src1` = 0, `alu_src2` = 0.
  - `wb_valid` = 0, `wb_addr` = 0, `wb_data` = 0.
  - `disp_value` = 0, `disp_valid` = 0, `error` = 0.
  - `instr_ready` = 1 from the first cycle after reset.
- Accept occurs at edge e0 where `instr_valid && instr_ready`. `instr_ready` drops to 0 from e0.
- LDI, CLR and DISP take effect at e1. `wb_valid` / `disp_valid` are high for the cycle after e1. `instr_ready` = 1 after e1. Throughput is one instruction per 2 cycles.
- Arithmetic ops:
  - `alu_op_code` becomes valid after e1.
  - With a nominal unit, `alu_done` is high in the cycle after e3 and is sampled at e4.
  - Writeback is visible after e4 and `instr_ready` = 1 after e4. Latency is 4 cycles accept-to-writeback.
- Timeout: the abort occurs at edge e1 + `ALU_TIMEOUT`.
- `instr_valid` held high with `instr_ready` low: nothing is accepted and `instr` is not re-sampled.

## Test plan
- Reset, then LDI R1,5; LDI R2,3 -> `wb_valid` pulses with (1, 0x0005) and (2, 0x0003); `instr_ready` low for exactly 1 cycle per instruction.
- ADD R3,R1,R2 against an arithmetic-unit model -> `alu_op_code` = 001, `alu_src1` = 5, `alu_src2` = 3 held through WAIT; `wb_data` = 0x0008 at e4; `alu_op_code` = 000 after e4 and the unit does not restart.
- SUBI R4,R1,imm7 = 7'b1000010 (−2) -> `alu_src2` = 0x0042; R4 = 0x0007. MUL R5,R1,R1 -> R5 = 0x0019.
- Hold `alu_done` low with `ALU_TIMEOUT` = 15 -> `error` = 1 at e16, no `wb_valid`, `alu_op_code` = 000, `instr_ready` = 1; a following LDI executes normally and `error` stays 1.
- DISP R5, then CLR, then DISP R5 -> `disp_value` 0x0019 then 0x0000, each with a 1-cycle `disp_valid` pulse.
- Assert `rst_n` = 0 in the middle of WAIT -> next cycle all outputs are at reset values, registers = 0, and a late `alu_done` causes no write.
